// File: rtl/bp_mmio_dev_router_pkg.sv
// Shared definitions for the uncached MMIO device router.
//   - Default four-entry device map (host, cfg, clint, cache), entry 0 in
//     the least-significant slice of the packed base/mask vectors.
//   - Helpers for the device-id width and the "no device matched" id.
package bp_mmio_dev_router_pkg;

  typedef enum logic [1:0] {
    e_dev_host  = 2'd0,
    e_dev_cfg   = 2'd1,
    e_dev_clint = 2'd2,
    e_dev_cache = 2'd3
  } bp_mmio_dev_e;

  localparam int unsigned dev_default_num_gp         = 4;
  localparam int unsigned dev_default_paddr_width_gp = 40;

  localparam logic [39:0] dev_addr_match_mask_gp = 40'hFF_FFF0_0000;

  localparam logic [4*40-1:0] dev_default_base_addr_gp =
    {40'h00_0040_0000, 40'h00_0030_0000, 40'h00_0020_0000, 40'h00_0010_0000};

  localparam logic [4*40-1:0] dev_default_mask_gp = {4{dev_addr_match_mask_gp}};

  // Ids 0..num_dev-1 name real devices; id num_dev means "unmapped".
  function automatic int unsigned dev_id_width_f(input int unsigned num_dev);
    return ((num_dev + 1) <= 1) ? 1 : $clog2(num_dev + 1);
  endfunction

  function automatic int unsigned dev_null_id_f(input int unsigned num_dev);
    return num_dev;
  endfunction

endpackage

// File: rtl/bp_mmio_addr_decode.sv
// Combinational address decoder.
//   addr_i : physical address of the incoming command
//   id_o   : index of the lowest-numbered matching device, or num_dev_p
//            when no entry of the base/mask table matches
module bp_mmio_addr_decode
  import bp_mmio_dev_router_pkg::*;
  #(parameter int unsigned num_dev_p     = dev_default_num_gp
  , parameter int unsigned paddr_width_p = dev_default_paddr_width_gp
  , parameter logic [num_dev_p*paddr_width_p-1:0] dev_base_addr_p = dev_default_base_addr_gp
  , parameter logic [num_dev_p*paddr_width_p-1:0] dev_mask_p      = dev_default_mask_gp
  , localparam int unsigned id_width_lp = dev_id_width_f(num_dev_p)
  )
  (input  logic [paddr_width_p-1:0] addr_i
  , output logic [id_width_lp-1:0]  id_o
  );

  localparam logic [id_width_lp-1:0] null_id_lp = id_width_lp'(dev_null_id_f(num_dev_p));

  logic [num_dev_p-1:0] match;

  for (genvar gi = 0; gi < num_dev_p; gi++) begin : g_match
    assign match[gi] =
      ((addr_i & dev_mask_p[gi*paddr_width_p +: paddr_width_p])
       == (dev_base_addr_p[gi*paddr_width_p +: paddr_width_p]
           & dev_mask_p[gi*paddr_width_p +: paddr_width_p]));
  end

  // Walk from the top entry down so the lowest matching index is the last
  // one written and therefore wins overlapping windows.
  always_comb begin
    id_o = null_id_lp;
    for (int i = int'(num_dev_p) - 1; i >= 0; i--) begin
      if (match[i]) id_o = id_width_lp'(i);
    end
  end

endmodule

// File: rtl/bp_mmio_dev_router.sv
// MMIO address-map router for the uncached device region.
//   clk_i / reset_i        : clock, asynchronous active-high reset
//   cmd_*                  : requester command (valid/ready), addr/we/data
//   dev_cmd_*              : per-device valid + ready, broadcast addr/we/data
//   dev_resp_*             : per-device response valid/data, consume (yumi)
//   resp_*                 : in-order response to requester (valid/yumi),
//                            err flags a command to an unmapped address
//   outstanding_o          : number of commands accepted but not answered
// Each accepted command's device id goes into a circular order queue; the
// queue head selects which device may return its response, so responses
// come back strictly in command order.
module bp_mmio_dev_router
  import bp_mmio_dev_router_pkg::*;
  #(parameter int unsigned num_dev_p         = dev_default_num_gp
  , parameter int unsigned paddr_width_p     = dev_default_paddr_width_gp
  , parameter int unsigned data_width_p      = 64
  , parameter int unsigned max_outstanding_p = 4
  , parameter logic [num_dev_p*paddr_width_p-1:0] dev_base_addr_p = dev_default_base_addr_gp
  , parameter logic [num_dev_p*paddr_width_p-1:0] dev_mask_p      = dev_default_mask_gp
  , localparam int unsigned outstanding_width_lp = $clog2(max_outstanding_p + 1)
  )
  (input  logic                              clk_i
  , input  logic                             reset_i

  , input  logic                             cmd_v_i
  , output logic                             cmd_ready_o
  , input  logic [paddr_width_p-1:0]         cmd_addr_i
  , input  logic                             cmd_we_i
  , input  logic [data_width_p-1:0]          cmd_data_i

  , output logic [num_dev_p-1:0]             dev_cmd_v_o
  , input  logic [num_dev_p-1:0]             dev_cmd_ready_i
  , output logic [paddr_width_p-1:0]         dev_cmd_addr_o
  , output logic                             dev_cmd_we_o
  , output logic [data_width_p-1:0]          dev_cmd_data_o

  , input  logic [num_dev_p-1:0]             dev_resp_v_i
  , input  logic [num_dev_p*data_width_p-1:0] dev_resp_data_i
  , output logic [num_dev_p-1:0]             dev_resp_yumi_o

  , output logic                             resp_v_o
  , output logic [data_width_p-1:0]          resp_data_o
  , output logic                             resp_err_o
  , input  logic                             resp_yumi_i

  , output logic [outstanding_width_lp-1:0]  outstanding_o
  );

  localparam int unsigned id_width_lp  = dev_id_width_f(num_dev_p);
  localparam int unsigned ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  localparam logic [id_width_lp-1:0]          null_id_lp  = id_width_lp'(dev_null_id_f(num_dev_p));
  localparam logic [outstanding_width_lp-1:0] depth_lp    = outstanding_width_lp'(max_outstanding_p);
  localparam logic [outstanding_width_lp-1:0] cnt_one_lp  = outstanding_width_lp'(1);
  localparam logic [ptr_width_lp-1:0]         last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);
  localparam logic [ptr_width_lp-1:0]         ptr_one_lp  = ptr_width_lp'(1);

  if (num_dev_p < 1) begin : g_bad_num_dev
    $error("bp_mmio_dev_router: num_dev_p must be >= 1");
  end
  if (max_outstanding_p < 2) begin : g_bad_depth
    $error("bp_mmio_dev_router: max_outstanding_p must be >= 2");
  end

  // ---------------------------------------------------------------- decode
  logic [id_width_lp-1:0] cmd_id;

  bp_mmio_addr_decode #(
    .num_dev_p       (num_dev_p),
    .paddr_width_p   (paddr_width_p),
    .dev_base_addr_p (dev_base_addr_p),
    .dev_mask_p      (dev_mask_p)
  ) u_decode (
    .addr_i (cmd_addr_i),
    .id_o   (cmd_id)
  );

  // ----------------------------------------------------------- order queue
  logic [id_width_lp-1:0]          order_mem_q [max_outstanding_p];
  logic [ptr_width_lp-1:0]         wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]         rptr_q, rptr_d;
  logic [outstanding_width_lp-1:0] count_q, count_d;

  logic                   queue_full, queue_empty;
  logic [id_width_lp-1:0] head_id;
  logic                   push, pop;

  assign queue_full  = (count_q == depth_lp);
  assign queue_empty = (count_q == '0);
  assign head_id     = order_mem_q[rptr_q];

  // Per-device one-hot views of the incoming id and of the queue head.
  logic [num_dev_p-1:0] cmd_sel, head_sel;

  for (genvar gi = 0; gi < num_dev_p; gi++) begin : g_sel
    assign cmd_sel[gi]  = (cmd_id == id_width_lp'(gi));
    assign head_sel[gi] = ~queue_empty & (head_id == id_width_lp'(gi));
  end

  logic cmd_null, head_null;

  assign cmd_null  = (cmd_id == null_id_lp);
  assign head_null = ~queue_empty & (head_id == null_id_lp);

  // ---------------------------------------------------------- command path
  // Full-queue check uses the registered count only, so a same-cycle pop
  // never opens a slot for a push.
  assign cmd_ready_o    = ~queue_full & (cmd_null | |(cmd_sel & dev_cmd_ready_i));
  assign dev_cmd_v_o    = cmd_sel & {num_dev_p{cmd_v_i & ~queue_full}};
  assign dev_cmd_addr_o = cmd_addr_i;
  assign dev_cmd_we_o   = cmd_we_i;
  assign dev_cmd_data_o = cmd_data_i;

  // --------------------------------------------------------- response path
  // Unmapped commands answer immediately from the queue; real devices only
  // see yumi when they own the head, so later responses simply wait.
  always_comb begin
    resp_data_o = '0;
    for (int i = 0; i < int'(num_dev_p); i++) begin
      if (head_sel[i]) resp_data_o = dev_resp_data_i[i*data_width_p +: data_width_p];
    end
  end

  assign resp_v_o        = head_null | |(head_sel & dev_resp_v_i);
  assign resp_err_o      = head_null;
  assign dev_resp_yumi_o = head_sel & {num_dev_p{resp_yumi_i}};
  assign outstanding_o   = count_q;

  assign push = cmd_v_i & cmd_ready_o;
  assign pop  = resp_yumi_i & resp_v_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_one_lp;
    if (pop)  rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_one_lp;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_one_lp;
      2'b01:   count_d = count_q - cnt_one_lp;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) order_mem_q[wptr_q] <= cmd_id;
  end

endmodule

// File: tb/tb_bp_mmio_dev_router.sv
// Randomized scoreboard bench for bp_mmio_dev_router.
module tb_bp_mmio_dev_router;

  localparam int NUM_DEV = 4;
  localparam int AW      = 40;
  localparam int DW      = 64;
  localparam int MAX_OUT = 4;

  // Device 3 overlaps devices 0..2 so lowest-index priority gets exercised.
  localparam logic [NUM_DEV*AW-1:0] BASE_P =
    {40'h00_0000_0000, 40'h00_0030_0000, 40'h00_0020_0000, 40'h00_0010_0000};
  localparam logic [NUM_DEV*AW-1:0] MASK_P =
    {40'hFF_FF80_0000, 40'hFF_FFF0_0000, 40'hFF_FFF0_0000, 40'hFF_FFF0_0000};

  logic [AW-1:0] map_base [NUM_DEV] = '{40'h10_0000, 40'h20_0000, 40'h30_0000, 40'h0};
  logic [AW-1:0] map_mask [NUM_DEV] =
    '{40'hFF_FFF0_0000, 40'hFF_FFF0_0000, 40'hFF_FFF0_0000, 40'hFF_FF80_0000};
  logic [AW-1:0] edge_addr [6] =
    '{40'h0F_FFFF, 40'h10_0000, 40'h3F_FFFF, 40'h7F_FFFF, 40'h80_0000, 40'h90_0000};

  logic                  clk, reset_i;
  logic                  cmd_v_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0]         cmd_addr_i;
  logic [DW-1:0]         cmd_data_i;
  logic [NUM_DEV-1:0]    dev_cmd_v_o, dev_cmd_ready_i;
  logic [AW-1:0]         dev_cmd_addr_o;
  logic                  dev_cmd_we_o;
  logic [DW-1:0]         dev_cmd_data_o;
  logic [NUM_DEV-1:0]    dev_resp_v_i, dev_resp_yumi_o;
  logic [NUM_DEV*DW-1:0] dev_resp_data_i;
  logic                  resp_v_o, resp_err_o, resp_yumi_i;
  logic [DW-1:0]         resp_data_o;
  logic [2:0]            outstanding_o;

  bp_mmio_dev_router #(
    .num_dev_p(NUM_DEV), .paddr_width_p(AW), .data_width_p(DW),
    .max_outstanding_p(MAX_OUT), .dev_base_addr_p(BASE_P), .dev_mask_p(MASK_P)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_data_i(cmd_data_i),
    .dev_cmd_v_o(dev_cmd_v_o), .dev_cmd_ready_i(dev_cmd_ready_i),
    .dev_cmd_addr_o(dev_cmd_addr_o), .dev_cmd_we_o(dev_cmd_we_o),
    .dev_cmd_data_o(dev_cmd_data_o),
    .dev_resp_v_i(dev_resp_v_i), .dev_resp_data_i(dev_resp_data_i),
    .dev_resp_yumi_o(dev_resp_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_yumi_i(resp_yumi_i), .outstanding_o(outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one entry per accepted command, in acceptance order.
  typedef struct { int id; logic [DW-1:0] data; } exp_t;
  typedef logic [DW-1:0] data_q_t [$];

  exp_t    exp_q [$];
  data_q_t dev_q [NUM_DEV];   // responses each device model still owes
  bit      dev_rv [NUM_DEV];  // device model currently presenting a response
  int      tests = 0;
  int      fails = 0;
  int      n_resp = 0;
  int      n_cmd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [AW-1:0] a);
    for (int d = 0; d < NUM_DEV; d++)
      if ((a & map_mask[d]) == (map_base[d] & map_mask[d])) return d;
    return NUM_DEV;
  endfunction

  function automatic logic [AW-1:0] gen_addr();
    logic [63:0] r;
    logic [AW-1:0] off;
    int k;
    k   = $urandom_range(0, 10);
    r   = {$urandom, $urandom};
    off = AW'($urandom_range(0, 32'hF_FFFF));
    case (k)
      0, 1:    return 40'h10_0000 + off;
      2, 3:    return 40'h20_0000 + off;
      4, 5:    return 40'h30_0000 + off;
      6:       return 40'h40_0000 + off;
      7:       return off;
      8:       return 40'h90_0000 + off;
      9:       return edge_addr[$urandom_range(0, 5)];
      default: return r[AW-1:0];
    endcase
  endfunction

  function automatic bit model_resp_v();
    if (exp_q.size() == 0) return 1'b0;
    if (exp_q[0].id == NUM_DEV) return 1'b1;
    return dev_rv[exp_q[0].id];
  endfunction

  // Response monitor: compares the requester/device response side against
  // the scoreboard head and retires entries on each consumed response.
  always @(negedge clk) begin
    int hid;
    bit erv;
    logic [NUM_DEV-1:0] eyumi;
    hid   = (exp_q.size() > 0) ? exp_q[0].id : -1;
    erv   = (hid == NUM_DEV) || (hid >= 0 && hid < NUM_DEV && dev_resp_v_i[hid]);
    eyumi = '0;
    if (hid >= 0 && hid < NUM_DEV && resp_yumi_i) eyumi[hid] = 1'b1;
    check("resp_v", 64'(resp_v_o), 64'(erv));
    check("dev_yumi", 64'(dev_resp_yumi_o), 64'(eyumi));
    check("outstanding", 64'(outstanding_o), 64'(exp_q.size()));
    if (erv) begin
      check("resp_err", 64'(resp_err_o), 64'(hid == NUM_DEV));
      check("resp_data", resp_data_o, (hid == NUM_DEV) ? 64'h0 : exp_q[0].data);
      if (resp_yumi_i) begin
        n_resp++;
        $display("[TB] resp %0d: id=%0d data=%h err=%b", n_resp, hid, resp_data_o, resp_err_o);
        void'(exp_q.pop_front());
      end
    end
    for (int d = 0; d < NUM_DEV; d++) begin
      if (dev_resp_yumi_o[d] && dev_q[d].size() > 0) begin
        void'(dev_q[d].pop_front());
        dev_rv[d] = 1'b0;
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a posedge.
  task automatic run_cycle(input int p_cmd, input int p_rdy, input int p_resp, input int p_yumi);
    int exp_id;
    bit exp_ready;
    logic [NUM_DEV-1:0] exp_dev_v;
    logic [DW-1:0] rdata;
    exp_t e;
    for (int d = 0; d < NUM_DEV; d++) begin
      dev_cmd_ready_i[d] = ($urandom_range(0, 99) < p_rdy);
      if (!dev_rv[d] && dev_q[d].size() > 0 && $urandom_range(0, 99) < p_resp) dev_rv[d] = 1'b1;
      dev_resp_v_i[d] = dev_rv[d];
      dev_resp_data_i[d*DW +: DW] = dev_rv[d] ? dev_q[d][0] : {$urandom, $urandom};
    end
    cmd_v_i    = ($urandom_range(0, 99) < p_cmd);
    cmd_addr_i = gen_addr();
    cmd_we_i   = 1'($urandom_range(0, 1));
    cmd_data_i = {$urandom, $urandom};
    exp_id     = ref_decode(cmd_addr_i);
    exp_ready  = (exp_q.size() < MAX_OUT) && (exp_id == NUM_DEV || dev_cmd_ready_i[exp_id]);
    exp_dev_v  = '0;
    if (cmd_v_i && exp_q.size() < MAX_OUT && exp_id != NUM_DEV) exp_dev_v[exp_id] = 1'b1;
    #1;
    resp_yumi_i = model_resp_v() && ($urandom_range(0, 99) < p_yumi);
    @(negedge clk);
    check("cmd_ready", 64'(cmd_ready_o), 64'(exp_ready));
    check("dev_cmd_v", 64'(dev_cmd_v_o), 64'(exp_dev_v));
    check("bcast_addr", 64'(dev_cmd_addr_o), 64'(cmd_addr_i));
    check("bcast_we_data", dev_cmd_data_o ^ 64'(dev_cmd_we_o), cmd_data_i ^ 64'(cmd_we_i));
    #1;
    if (cmd_v_i && exp_ready) begin
      rdata  = {$urandom, $urandom};
      e.id   = exp_id;
      e.data = (exp_id == NUM_DEV) ? '0 : rdata;
      exp_q.push_back(e);
      if (exp_id < NUM_DEV) dev_q[exp_id].push_back(rdata);
      n_cmd++;
      $display("[TB] cmd %0d: addr=%h we=%b -> id=%0d", n_cmd, cmd_addr_i, cmd_we_i, exp_id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pre;
    reset_i = 1'b1;
    cmd_v_i = 1'b0; cmd_addr_i = '0; cmd_we_i = 1'b0; cmd_data_i = '0;
    dev_cmd_ready_i = '0; dev_resp_v_i = '0; dev_resp_data_i = '0; resp_yumi_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outstanding", 64'(outstanding_o), 64'h0);
    check("reset_resp_v", 64'(resp_v_o), 64'h0);
    check("reset_dev_cmd_v", 64'(dev_cmd_v_o), 64'h0);
    reset_i = 1'b0;

    repeat (600) run_cycle(60, 75, 40, 70);
    // Stall every response so the queue fills, then pop only unmapped heads
    // while commands keep being offered against the full queue.
    repeat (40) run_cycle(100, 100, 0, 0);
    repeat (10) run_cycle(100, 100, 0, 100);

    // Asynchronous reset between clock edges with work still in flight.
    cmd_v_i = 1'b0; resp_yumi_i = 1'b0; dev_resp_v_i = '0;
    pre = exp_q.size();
    #2;
    reset_i = 1'b1;
    exp_q.delete();
    for (int d = 0; d < NUM_DEV; d++) begin
      dev_q[d].delete();
      dev_rv[d] = 1'b0;
    end
    #1;
    $display("[TB] async reset with %0d in flight", pre);
    check("async_rst_outstanding", 64'(outstanding_o), 64'h0);
    check("async_rst_resp_v", 64'(resp_v_o), 64'h0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    repeat (400) run_cycle(80, 60, 30, 60);

    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      run_cycle(0, 100, 100, 100);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
    end
    check("final_outstanding", 64'(outstanding_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
